// File: rtl/connect_count_job_feeder_pkg.sv
// rtl/connect_count_job_feeder_pkg.sv - shared widths and helpers for the connect-count job feeder
`ifndef COUNT_CONNECTED_DEFS_VH
`define COUNT_CONNECTED_DEFS_VH
`define GRAPH_WIDTH 128
`define CONNECT_COUNT_WIDTH 6
`define STAT_COUNTER_WIDTH 32
`endif

package connect_count_job_feeder_pkg;

  localparam int GRAPH_W = `GRAPH_WIDTH;
  localparam int COUNT_W = `CONNECT_COUNT_WIDTH;
  localparam int STAT_W  = `STAT_COUNTER_WIDTH;

  localparam logic [STAT_W-1:0] STAT_ONE = 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + STAT_ONE;
  endfunction

endpackage

// File: rtl/connect_count_job_feeder_job_fifo.sv
// rtl/connect_count_job_feeder_job_fifo.sv - first-word-fall-through job FIFO with registered ready
module job_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = DEPTH;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ready_q, ready_d;
  logic                  push, pop;

  // Ready comes from a register so a pop on a full FIFO cannot admit a push that same cycle.
  assign push = wr_valid_i & ready_q;
  assign pop  = rd_en_i & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    ready_d = (level_d != FULL_LEVEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign wr_ready_o = ready_q;
  assign rd_valid_o = (level_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/connect_count_job_feeder.sv
// rtl/connect_count_job_feeder.sv - job FIFO plus fixed-latency start and lagged starting-count delivery
module connect_count_job_feeder
  import connect_count_job_feeder_pkg::*;
#(
  parameter int EXTRA_DATA_WIDTH           = 10,
  parameter int DATA_IN_LATENCY            = 4,
  parameter int STARTING_CONNECT_COUNT_LAG = 3,
  parameter int FIFO_DEPTH_LOG2            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        jobValid,
  output logic                        jobReady,
  input  logic [GRAPH_W-1:0]          jobGraph,
  input  logic [COUNT_W-1:0]          jobStartCount,
  input  logic [EXTRA_DATA_WIDTH-1:0] jobExtraData,
  input  logic                        request,
  output logic                        start,
  output logic [GRAPH_W-1:0]          graphIn,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  output logic [COUNT_W-1:0]          startingConnectCountIn_DELAYED,
  output logic [STAT_W-1:0]           jobsIssued,
  output logic [STAT_W-1:0]           missedRequests,
  output logic [FIFO_DEPTH_LOG2:0]    fifoLevel
);

  localparam int JOB_W = GRAPH_W + COUNT_W + EXTRA_DATA_WIDTH;
  localparam int LAT   = DATA_IN_LATENCY;
  localparam int LAG   = STARTING_CONNECT_COUNT_LAG;

  logic [JOB_W-1:0]   head;
  logic               head_valid;
  logic               pop, miss;
  logic [JOB_W-1:0]   tail_job;

  logic [LAT-1:0]     dv_q;
  logic [JOB_W-1:0]   dd_q [LAT];
  logic [COUNT_W-1:0] cnt_q [LAG];
  logic [STAT_W-1:0]  issued_q, issued_d;
  logic [STAT_W-1:0]  missed_q, missed_d;

  job_fifo #(
    .WIDTH      (JOB_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_job_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (jobValid),
    .wr_ready_o (jobReady),
    .wr_data_i  ({jobGraph, jobStartCount, jobExtraData}),
    .rd_en_i    (request),
    .rd_valid_o (head_valid),
    .rd_data_o  (head),
    .level_o    (fifoLevel)
  );

  assign pop      = request & head_valid;
  assign miss     = request & ~head_valid;
  assign tail_job = dd_q[LAT-1];

  always_comb begin
    issued_d = issued_q;
    missed_d = missed_q;
    if (dv_q[LAT-1]) issued_d = issued_q + STAT_ONE;
    if (miss)        missed_d = sat_inc(missed_q);
  end

  // Empty slots carry zero data so nothing stale can reach the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q <= '0;
      for (int i = 0; i < LAT; i++) dd_q[i] <= '0;
      for (int j = 0; j < LAG; j++) cnt_q[j] <= '0;
      issued_q <= '0;
      missed_q <= '0;
    end else begin
      dv_q[0] <= pop;
      dd_q[0] <= pop ? head : '0;
      for (int i = 1; i < LAT; i++) begin
        dv_q[i] <= dv_q[i-1];
        dd_q[i] <= dd_q[i-1];
      end
      cnt_q[0] <= dv_q[LAT-1] ? tail_job[EXTRA_DATA_WIDTH +: COUNT_W] : '0;
      for (int j = 1; j < LAG; j++) cnt_q[j] <= cnt_q[j-1];
      issued_q <= issued_d;
      missed_q <= missed_d;
    end
  end

  assign start                          = dv_q[LAT-1];
  assign graphIn                        = start ? tail_job[JOB_W-1 -: GRAPH_W] : '0;
  assign extraDataIn                    = start ? tail_job[EXTRA_DATA_WIDTH-1:0] : '0;
  assign startingConnectCountIn_DELAYED = cnt_q[LAG-1];
  assign jobsIssued                     = issued_q;
  assign missedRequests                 = missed_q;

endmodule

// File: tb/tb_connect_count_job_feeder.sv
// tb/tb_connect_count_job_feeder.sv - table-driven and directed checks of the job feeder
module tb_connect_count_job_feeder;

  logic         clk;
  logic         rst;
  logic         jobValid;
  logic         jobReady;
  logic [127:0] jobGraph;
  logic [5:0]   jobStartCount;
  logic [9:0]   jobExtraData;
  logic         request;
  logic         start;
  logic [127:0] graphIn;
  logic [9:0]   extraDataIn;
  logic [5:0]   cntDelayed;
  logic [31:0]  jobsIssued;
  logic [31:0]  missedRequests;
  logic [4:0]   fifoLevel;

  int checks = 0;
  int errors = 0;

  connect_count_job_feeder #(
    .EXTRA_DATA_WIDTH           (10),
    .DATA_IN_LATENCY            (4),
    .STARTING_CONNECT_COUNT_LAG (3),
    .FIFO_DEPTH_LOG2            (4)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .jobValid                       (jobValid),
    .jobReady                       (jobReady),
    .jobGraph                       (jobGraph),
    .jobStartCount                  (jobStartCount),
    .jobExtraData                   (jobExtraData),
    .request                        (request),
    .start                          (start),
    .graphIn                        (graphIn),
    .extraDataIn                    (extraDataIn),
    .startingConnectCountIn_DELAYED (cntDelayed),
    .jobsIssued                     (jobsIssued),
    .missedRequests                 (missedRequests),
    .fifoLevel                      (fifoLevel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic jv;
    int   jidx;
    logic req;
    logic e_start;
    int   e_job;
    int   e_cnt_job;
    int   e_lvl;
    logic e_rdy;
    int   e_issued;
  } vec_t;

  vec_t vt[16];

  function automatic logic [127:0] graph_of(input int j);
    logic [31:0] w;
    w = 32'hA5A50000 + 32'(j);
    return {w, ~w, w ^ 32'h0F0F0F0F, w};
  endfunction

  function automatic logic [9:0] tag_of(input int j);
    return 10'(j + 100);
  endfunction

  function automatic logic [5:0] cnt_of(input int j);
    return 6'(j + 7);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_job(input int j);
    jobGraph      = graph_of(j);
    jobStartCount = cnt_of(j);
    jobExtraData  = tag_of(j);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jobValid = 1'b0;
    request = 1'b0;
    jobGraph = '0;
    jobStartCount = '0;
    jobExtraData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    next_cycle();
  endtask

  task automatic sv(input int k, input logic jv, input int jidx, input logic req,
                    input logic es, input int ejob, input int ecnt, input int lvl,
                    input logic rdy, input int iss);
    vt[k].jv = jv; vt[k].jidx = jidx; vt[k].req = req;
    vt[k].e_start = es; vt[k].e_job = ejob; vt[k].e_cnt_job = ecnt;
    vt[k].e_lvl = lvl; vt[k].e_rdy = rdy; vt[k].e_issued = iss;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // four jobs queued, then request held four cycles: starts at 8..11, counts at 11..14
    //  k  jv jidx req  start job cnt lvl rdy issued
    sv(0,  1, 0,  0,   0, -1, -1, 0, 1, 0);
    sv(1,  1, 1,  0,   0, -1, -1, 1, 1, 0);
    sv(2,  1, 2,  0,   0, -1, -1, 2, 1, 0);
    sv(3,  1, 3,  0,   0, -1, -1, 3, 1, 0);
    sv(4,  0, -1, 1,   0, -1, -1, 4, 1, 0);
    sv(5,  0, -1, 1,   0, -1, -1, 3, 1, 0);
    sv(6,  0, -1, 1,   0, -1, -1, 2, 1, 0);
    sv(7,  0, -1, 1,   0, -1, -1, 1, 1, 0);
    sv(8,  0, -1, 0,   1, 0,  -1, 0, 1, 0);
    sv(9,  0, -1, 0,   1, 1,  -1, 0, 1, 1);
    sv(10, 0, -1, 0,   1, 2,  -1, 0, 1, 2);
    sv(11, 0, -1, 0,   1, 3,  0,  0, 1, 3);
    sv(12, 0, -1, 0,   0, -1, 1,  0, 1, 4);
    sv(13, 0, -1, 0,   0, -1, 2,  0, 1, 4);
    sv(14, 0, -1, 0,   0, -1, 3,  0, 1, 4);
    sv(15, 0, -1, 0,   0, -1, -1, 0, 1, 4);

    // reset state while rst is held
    rst = 1'b1; jobValid = 1'b0; request = 1'b0;
    jobGraph = '0; jobStartCount = '0; jobExtraData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", jobReady, 0);
    chk("rst_start", start, 0);
    chk("rst_graph", graphIn, 0);
    chk("rst_tag", extraDataIn, 0);
    chk("rst_cnt", cntDelayed, 0);
    chk("rst_level", fifoLevel, 0);
    chk("rst_issued", jobsIssued, 0);
    chk("rst_missed", missedRequests, 0);

    // table: FIFO order, back-to-back requests
    do_reset();
    for (int k = 0; k < 16; k++) begin
      jobValid = vt[k].jv;
      if (vt[k].jv) set_job(vt[k].jidx);
      request = vt[k].req;
      @(negedge clk);
      chk($sformatf("tbl%0d_start", k), start, vt[k].e_start);
      chk($sformatf("tbl%0d_graph", k), graphIn, (vt[k].e_job >= 0) ? graph_of(vt[k].e_job) : 128'h0);
      chk($sformatf("tbl%0d_tag", k), extraDataIn, (vt[k].e_job >= 0) ? tag_of(vt[k].e_job) : 10'h0);
      chk($sformatf("tbl%0d_cnt", k), cntDelayed, (vt[k].e_cnt_job >= 0) ? cnt_of(vt[k].e_cnt_job) : 6'h0);
      chk($sformatf("tbl%0d_level", k), fifoLevel, 5'(vt[k].e_lvl));
      chk($sformatf("tbl%0d_ready", k), jobReady, vt[k].e_rdy);
      chk($sformatf("tbl%0d_issued", k), jobsIssued, 32'(vt[k].e_issued));
      next_cycle();
    end
    jobValid = 1'b0; request = 1'b0;

    // single job, request at cycle 10
    do_reset();
    for (int c = 0; c < 20; c++) begin
      jobValid = (c == 0);
      jobGraph = 128'h1; jobStartCount = 6'd5; jobExtraData = 10'd3;
      request = (c == 10);
      @(negedge clk);
      chk($sformatf("one_c%0d_start", c), start, (c == 14));
      chk($sformatf("one_c%0d_graph", c), graphIn, (c == 14) ? 128'h1 : 128'h0);
      chk($sformatf("one_c%0d_tag", c), extraDataIn, (c == 14) ? 10'd3 : 10'd0);
      chk($sformatf("one_c%0d_cnt", c), cntDelayed, (c == 17) ? 6'd5 : 6'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("one_issued", jobsIssued, 1);
    chk("one_missed", missedRequests, 0);
    next_cycle();

    // empty FIFO, requests at 5,6,7
    do_reset();
    for (int c = 0; c < 16; c++) begin
      request = (c >= 5 && c <= 7);
      @(negedge clk);
      chk($sformatf("miss_c%0d_start", c), start, 0);
      next_cycle();
    end
    request = 1'b0;
    @(negedge clk);
    chk("miss_count", missedRequests, 3);
    chk("miss_issued", jobsIssued, 0);
    next_cycle();

    // fill to 16, hold the 17th until a pop frees a slot
    do_reset();
    for (int c = 0; c < 16; c++) begin
      jobValid = 1'b1; set_job(c);
      next_cycle();
    end
    set_job(16);
    @(negedge clk);
    chk("full_level", fifoLevel, 16);
    chk("full_ready", jobReady, 0);
    next_cycle();
    request = 1'b1;
    @(negedge clk);
    chk("fullpop_ready", jobReady, 0);
    chk("fullpop_level", fifoLevel, 16);
    next_cycle();
    request = 1'b0;
    @(negedge clk);
    chk("afterpop_level", fifoLevel, 15);
    chk("afterpop_ready", jobReady, 1);
    next_cycle();
    jobValid = 1'b0;
    @(negedge clk);
    chk("refill_level", fifoLevel, 16);
    chk("refill_ready", jobReady, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("full_first_start", start, 1);
    chk("full_first_graph", graphIn, graph_of(0));
    next_cycle();

    // push and request together on an empty FIFO
    do_reset();
    jobValid = 1'b1; set_job(40); request = 1'b1;
    @(negedge clk);
    chk("same_level0", fifoLevel, 0);
    next_cycle();
    jobValid = 1'b0;
    @(negedge clk);
    chk("same_level1", fifoLevel, 1);
    chk("same_missed", missedRequests, 1);
    next_cycle();
    request = 1'b0;
    @(negedge clk);
    chk("same_level2", fifoLevel, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("same_c4_start", start, 0);
    next_cycle();
    @(negedge clk);
    chk("same_c5_start", start, 1);
    chk("same_c5_tag", extraDataIn, tag_of(40));
    chk("same_c5_level", fifoLevel, 0);
    next_cycle();

    // reset with two starts in flight and one job still queued
    do_reset();
    for (int c = 0; c < 7; c++) begin
      jobValid = (c <= 2);
      set_job(50 + c);
      request = (c == 3 || c == 4);
      next_cycle();
    end
    @(negedge clk);
    chk("inflight_start", start, 1);
    chk("inflight_level", fifoLevel, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_start", start, 0);
    chk("arst_graph", graphIn, 0);
    chk("arst_tag", extraDataIn, 0);
    chk("arst_level", fifoLevel, 0);
    chk("arst_ready", jobReady, 0);
    chk("arst_issued", jobsIssued, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("post_c%0d_start", c), start, 0);
      chk($sformatf("post_c%0d_cnt", c), cntDelayed, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("post_level", fifoLevel, 0);
    chk("post_ready", jobReady, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
